// File: rtl/md_if.sv
// Operand/handshake bundle between the EX stage and the multiply/divide unit.
interface md_if;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mdOp, dataA, dataB, req,
    input  busy, hi, lo
  );

  modport slave (
    input  start, mdOp, dataA, dataB, req,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO. The result is computed at the
// accept edge and held until a fixed-length busy window expires, which keeps
// the hazard unit's stall timing independent of the operand values.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy;
  logic               accept;
  logic               is_long;
  logic               is_div;
  logic               done;
  logic [63:0]        res_p1;
  logic               wr_p1;
  logic [31:0]        hi_q, lo_q;

  // Full 64-bit {hi,lo} result. Signed divide runs at 33 bits so that
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of
  // overflowing; a zero divisor returns 0 (never committed).
  function automatic logic [63:0] md_calc(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic signed [32:0] da, db, q, r;
    md_calc = 64'd0;
    case (op)
      OP_MULT: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        md_calc = sp;
      end
      OP_MULTU: md_calc = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        da = {a[31], a};
        db = {b[31], b};
        if (b != 32'd0) begin
          q = da / db;
          r = da % db;
          md_calc = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b != 32'd0) md_calc = {a % b, a / b};
      end
      default: md_calc = 64'd0;
    endcase
  endfunction

  assign busy    = (state_q == RUN);
  assign accept  = md.start && !md.req && !busy &&
                   (md.mdOp != 3'd0) && (md.mdOp != 3'd7);
  assign is_long = (md.mdOp >= OP_MULT) && (md.mdOp <= OP_DIVU);
  assign is_div  = (md.mdOp == OP_DIV) || (md.mdOp == OP_DIVU);
  assign done    = busy && (cnt_q == CNT_W'(1));

  // Next-state and counter: load on a long-op accept, count down while running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && is_long) begin
          state_d = RUN;
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; reset drops any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accept stage: hold the result and whether it may be committed (not /0).
  always_ff @(posedge clk) begin
    if (accept && is_long) begin
      res_p1 <= md_calc(md.mdOp, md.dataA, md.dataB);
      wr_p1  <= !(is_div && (md.dataB == 32'd0));
    end
  end

  // Commit stage: HI/LO change only at completion, mthi/mtlo or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (done) begin
      if (wr_p1) begin
        hi_q <= res_p1[63:32];
        lo_q <= res_p1[31:0];
      end
    end else if (accept && (md.mdOp == OP_MTHI)) begin
      hi_q <= md.dataA;
    end else if (accept && (md.mdOp == OP_MTLO)) begin
      lo_q <= md.dataA;
    end
  end

  assign md.busy = busy;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver predicts each long op's HI/LO and
// busy length from plain 64-bit arithmetic; the monitor checks them when busy
// falls, and checks the cleared state after every reset cycle.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  md_if bus ();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  // Reference result of a long op given the current HI/LO.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h,
                                         input logic [31:0] l);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin sq = sa * sb; return sq; end
      3'd2: begin p = 64'(a) * 64'(b); return p; end
      3'd3: begin
        if (b == 32'd0) return {h, l};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {h, l};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
      default: return {h, l};
    endcase
  endfunction

  task automatic junk();
    bus.start = ($urandom_range(0, 2) != 0);
    bus.mdOp  = 3'($urandom_range(0, 7));
    bus.dataA = $urandom;
    bus.dataB = $urandom;
    bus.req   = ($urandom_range(0, 3) == 0);
  endtask

  // Called at a negedge; waits for idle (hammering ignored starts/req while
  // busy), presents one op for one cycle and records the expectation.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input bit push, input string name);
    int          guard;
    logic [63:0] res;
    exp_t        e;
    guard = 0;
    while (bus.busy !== 1'b0) begin
      junk();
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        $display("FAIL busy_timeout %s: busy=%b required 0 within 200 cycles", name, bus.busy);
        $fatal(1, "busy never dropped");
      end
    end
    bus.start = 1'b1;
    bus.mdOp  = op;
    bus.dataA = a;
    bus.dataB = b;
    bus.req   = r;
    if (!r && op >= 3'd1 && op <= 3'd6) begin
      if (op == 3'd5) m_hi = a;
      else if (op == 3'd6) m_lo = a;
      else begin
        res    = ref_md(op, a, b, m_hi, m_lo);
        m_hi   = res[63:32];
        m_lo   = res[31:0];
        e.name = name;
        e.len  = (op <= 3'd2) ? MC : DC;
        e.hi   = m_hi;
        e.lo   = m_lo;
        if (push) sbq.push_back(e);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.req   = 1'b0;
  endtask

  // Monitor: reset state after each reset edge, result and busy length at busy fall.
  initial begin
    logic rs;
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(posedge clk);
      rs = reset;
      @(negedge clk);
      if (rs) begin
        tests++;
        if (bus.busy !== 1'b0) begin
          fails++;
          $display("FAIL reset_busy: busy=%b required 0", bus.busy);
        end
        tests++;
        if (bus.hi !== 32'd0) begin
          fails++;
          $display("FAIL reset_hi: hi=%h required 00000000", bus.hi);
        end
        tests++;
        if (bus.lo !== 32'd0) begin
          fails++;
          $display("FAIL reset_lo: lo=%h required 00000000", bus.lo);
        end
        cnt = 0;
      end else if (bus.busy === 1'b1) begin
        cnt++;
      end else if (cnt > 0) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_busy: busy ran %0d cycles, required no busy window", cnt);
        end else begin
          e = sbq.pop_front();
          tests++;
          if (cnt != e.len) begin
            fails++;
            $display("FAIL %s busy_len: got %0d cycles required %0d", e.name, cnt, e.len);
          end
          tests++;
          if (bus.hi !== e.hi) begin
            fails++;
            $display("FAIL %s hi: got %h required %h", e.name, bus.hi, e.hi);
          end
          tests++;
          if (bus.lo !== e.lo) begin
            fails++;
            $display("FAIL %s lo: got %h required %h", e.name, bus.lo, e.lo);
          end
        end
        cnt = 0;
      end
    end
  end

  // Driver: directed cases first, then randomized ops.
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        r;
    int          guard;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mdOp  = 3'd0;
    bus.dataA = 32'd0;
    bus.dataB = 32'd0;
    bus.req   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    do_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b1, "mult_m3x5");
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, "multu_max");
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, "div_m7by2");
    do_op(3'd5, 32'h12345678, 32'd0, 1'b0, 1'b1, "mthi");
    do_op(3'd6, 32'h9ABCDEF0, 32'd0, 1'b0, 1'b1, "mtlo");
    do_op(3'd4, 32'd7, 32'd0, 1'b0, 1'b1, "divu_7by0");
    do_op(3'd1, 32'd3, 32'd4, 1'b1, 1'b1, "mult_req_blocked");
    do_op(3'd0, 32'd3, 32'd4, 1'b0, 1'b1, "op_none");
    do_op(3'd7, 32'd3, 32'd4, 1'b0, 1'b1, "op_rsvd");
    do_op(3'd4, 32'd1, 32'd0, 1'b0, 1'b1, "divu_unchanged");
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, "div_ovf");
    do_op(3'd3, 32'd100, 32'hFFFFFFF9, 1'b0, 1'b1, "div_100bym7");
    do_op(3'd4, 32'hFFFFFFF0, 32'd7, 1'b0, 1'b1, "divu_big");

    // Reset in the third busy cycle of a div: op is dropped, no late write.
    do_op(3'd3, 32'd123, 32'd4, 1'b0, 1'b0, "div_aborted");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    do_op(3'd4, 32'd5, 32'd0, 1'b0, 1'b1, "after_reset");

    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      r = ($urandom_range(0, 5) == 0);
      do_op(op, a, b, r, 1'b1, $sformatf("rand%0d_op%0d", i, op));
    end
    do_op(3'd4, 32'd9, 32'd0, 1'b0, 1'b1, "final_hilo");

    guard = 0;
    while (bus.busy !== 1'b0 || sbq.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        $display("FAIL drain: %0d results still pending, required 0", sbq.size());
        $fatal(1, "scoreboard did not drain");
      end
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
